// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two valid/ready requesters
// and returns registered, tagged results on a single response channel.
module alu_arbiter #(
   parameter int INPUT_WIDTH = 16,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req0_valid,
   output logic                   req0_ready,
   input  logic [INPUT_WIDTH-1:0] req0_a,
   input  logic [INPUT_WIDTH-1:0] req0_b,
   input  logic [3:0]             req0_cop,
   input  logic                   req1_valid,
   output logic                   req1_ready,
   input  logic [INPUT_WIDTH-1:0] req1_a,
   input  logic [INPUT_WIDTH-1:0] req1_b,
   input  logic [3:0]             req1_cop,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic                   rsp_id,
   output logic [INPUT_WIDTH-1:0] rsp_result,
   output logic                   rsp_ovf,
   output logic                   rsp_err,
   output logic [INPUT_WIDTH-1:0] alu_a,
   output logic [INPUT_WIDTH-1:0] alu_b,
   output logic [3:0]             alu_cop,
   input  logic [INPUT_WIDTH-1:0] alu_result,
   input  logic                   alu_ovf,
   output logic [CNT_WIDTH-1:0]   ops_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                 state_reg, state_next;
   logic                   last_grant_reg;
   logic [INPUT_WIDTH-1:0] a_reg, b_reg;
   logic [3:0]             cop_reg;
   logic                   id_reg;
   logic [INPUT_WIDTH-1:0] rsp_result_reg;
   logic                   rsp_ovf_reg;
   logic                   rsp_err_reg;
   logic [CNT_WIDTH-1:0]   ops_done_reg;

   logic grant;
   logic accept;
   logic cop_legal;

   // Only the current-cycle valids matter, so a withdrawn request can never hold a grant.
   always_comb begin
      grant = req1_valid;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant_reg;
      end
   end

   assign req0_ready = (state_reg == IDLE) && req0_valid && !grant;
   assign req1_ready = (state_reg == IDLE) && req1_valid && grant;
   assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
   assign cop_legal  = !(cop_reg[3] || (cop_reg == 4'b0101));

   always_comb begin
      state_next = state_reg;
      alu_a      = '0;
      alu_b      = '0;
      alu_cop    = 4'b0000;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = EXEC;
            end
         end
         EXEC: begin
            alu_a      = a_reg;
            alu_b      = b_reg;
            alu_cop    = cop_legal ? cop_reg : 4'b0000;
            state_next = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_reg <= 1'b1;
         a_reg          <= '0;
         b_reg          <= '0;
         cop_reg        <= 4'b0000;
         id_reg         <= 1'b0;
         rsp_result_reg <= '0;
         rsp_ovf_reg    <= 1'b0;
         rsp_err_reg    <= 1'b0;
         ops_done_reg   <= '0;
      end else begin
         if (state_reg == IDLE && accept) begin
            a_reg          <= grant ? req1_a : req0_a;
            b_reg          <= grant ? req1_b : req0_b;
            cop_reg        <= grant ? req1_cop : req0_cop;
            id_reg         <= grant;
            last_grant_reg <= grant;
         end
         // Illegal opcodes return a clean zero result regardless of what the ALU does with 0000.
         if (state_reg == EXEC) begin
            rsp_result_reg <= cop_legal ? alu_result : '0;
            rsp_ovf_reg    <= cop_legal ? alu_ovf : 1'b0;
            rsp_err_reg    <= ~cop_legal;
         end
         if (state_reg == RESP && rsp_ready) begin
            ops_done_reg <= ops_done_reg + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         end
      end
   end

   assign rsp_valid  = (state_reg == RESP);
   assign rsp_id     = id_reg;
   assign rsp_result = rsp_result_reg;
   assign rsp_ovf    = rsp_ovf_reg;
   assign rsp_err    = rsp_err_reg;
   assign ops_done   = ops_done_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic, compared each
// cycle against a transaction-level model (pending op + its age in cycles).
module tb_alu_arbiter;
   localparam int W  = 16;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0_valid, req1_valid, req0_ready, req1_ready;
   logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
   logic [3:0]    req0_cop, req1_cop;
   logic          rsp_valid, rsp_ready, rsp_id, rsp_ovf, rsp_err;
   logic [W-1:0]  rsp_result, alu_a, alu_b, alu_result;
   logic [3:0]    alu_cop;
   logic          alu_ovf;
   logic [CW-1:0] ops_done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.INPUT_WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_cop(req0_cop),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_cop(req1_cop),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cop(alu_cop), .alu_result(alu_result),
      .alu_ovf(alu_ovf), .ops_done(ops_done)
   );

   // Behavioural ALU attached to the arbiter: {ovf, result}
   function automatic logic [W:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] c);
      case (c)
         4'd0:    alu_fn = {1'b0, a & b};
         4'd1:    alu_fn = {1'b0, a} + {1'b0, b};
         4'd2:    alu_fn = {1'b0, a} - {1'b0, b};
         4'd3:    alu_fn = {1'b0, a | b};
         4'd4:    alu_fn = (a == b) ? 17'd1 : 17'd0;
         4'd6:    alu_fn = {1'b0, a ^ b};
         4'd7:    alu_fn = {1'b0, ~a};
         default: alu_fn = '0;
      endcase
   endfunction

   assign {alu_ovf, alu_result} = alu_fn(alu_a, alu_b, alu_cop);

   function automatic bit is_legal(input logic [3:0] c);
      return (c <= 4'd7) && (c != 4'd5);
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: at most one operation in flight, tracked by its age since acceptance.
   bit          m_known = 0;
   bit          m_busy;
   int          m_age;
   bit          m_last;
   int          m_cnt;
   bit          m_id;
   logic [W-1:0] m_a, m_b;
   logic [3:0]  m_cop;
   logic [W:0]  m_res;
   bit          m_err;
   int          n_grant0 = 0, n_grant1 = 0;

   task automatic cycle();
      bit g, e_r0, e_r1, in_exec, in_resp;
      #1;
      g = req1_valid;
      if (req0_valid && req1_valid) g = !m_last;
      e_r0    = m_known && !m_busy && req0_valid && !g;
      e_r1    = m_known && !m_busy && req1_valid && g;
      in_exec = m_busy && m_age == 1;
      in_resp = m_busy && m_age >= 2;
      if (m_known) begin
         check_val("req0_ready", req0_ready, e_r0);
         check_val("req1_ready", req1_ready, e_r1);
         check_val("rsp_valid", rsp_valid, in_resp);
         check_val("ops_done", ops_done, m_cnt);
         check_val("alu_a", alu_a, in_exec ? m_a : 0);
         check_val("alu_b", alu_b, in_exec ? m_b : 0);
         check_val("alu_cop", alu_cop, (in_exec && is_legal(m_cop)) ? m_cop : 0);
         if (in_resp) begin
            check_val("rsp_id", rsp_id, m_id);
            check_val("rsp_result", rsp_result, m_res[W-1:0]);
            check_val("rsp_ovf", rsp_ovf, m_res[W]);
            check_val("rsp_err", rsp_err, m_err);
         end
      end
      @(posedge clk);
      if (reset) begin
         m_known = 1; m_busy = 0; m_age = 0; m_last = 1; m_cnt = 0;
      end else if (m_known) begin
         if (!m_busy) begin
            if (e_r0 || e_r1) begin
               m_busy = 1; m_age = 1; m_id = g; m_last = g;
               m_a   = g ? req1_a : req0_a;
               m_b   = g ? req1_b : req0_b;
               m_cop = g ? req1_cop : req0_cop;
               m_err = !is_legal(m_cop);
               m_res = m_err ? '0 : alu_fn(m_a, m_b, m_cop);
               if (g) n_grant1++; else n_grant0++;
            end
         end else if (m_age == 1) begin
            m_age = 2;
         end else begin
            m_age++;
            if (rsp_ready) begin
               m_busy = 0;
               m_cnt  = (m_cnt + 1) % (1 << CW);
               $display("RSP id=%0d cop=%0h result=%04h ovf=%0d err=%0d ops_done=%0d",
                        m_id, m_cop, m_res[W-1:0], m_res[W], m_err, m_cnt);
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic set_req0(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [3:0] c);
      req0_valid = v; req0_a = a; req0_b = b; req0_cop = c;
   endtask

   task automatic set_req1(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [3:0] c);
      req1_valid = v; req1_a = a; req1_b = b; req1_cop = c;
   endtask

   task automatic idle_inputs();
      set_req0(0, 0, 0, 0);
      set_req1(0, 0, 0, 0);
      rsp_ready = 0;
      reset = 0;
   endtask

   initial begin
      idle_inputs();
      reset = 1;
      @(negedge clk);
      cycle();
      cycle();
      reset = 0;

      // Single request from req0: add 5+3
      set_req0(1, 16'h0005, 16'h0003, 4'b0001);
      rsp_ready = 1;
      cycle();
      set_req0(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle();

      // Both requesters continuously valid: grants alternate
      n_grant0 = 0; n_grant1 = 0;
      set_req0(1, 16'd3, 16'd5, 4'b0010);
      set_req1(1, 16'hFFFF, 16'd1, 4'b0001);
      for (int i = 0; i < 12; i++) cycle();
      check_val("alternating_grants", {n_grant0[15:0], n_grant1[15:0]}, {16'd2, 16'd2});
      set_req0(0, 0, 0, 0);
      set_req1(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle();

      // Backpressure: response held for 5 cycles while req1 waits
      rsp_ready = 0;
      set_req0(1, 16'h1234, 16'h00FF, 4'b0011);
      cycle();
      set_req0(0, 0, 0, 0);
      set_req1(1, 16'h00F0, 16'h0F0F, 4'b0110);
      for (int i = 0; i < 6; i++) cycle();
      rsp_ready = 1;
      cycle();
      cycle();
      set_req1(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle();

      // Illegal opcode from req1, then a legal compare
      set_req1(1, 16'hAAAA, 16'h5555, 4'b1010);
      for (int i = 0; i < 3; i++) cycle();
      set_req1(1, 16'd7, 16'd7, 4'b0100);
      cycle();
      set_req1(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle();

      // Reset during EXEC, then during RESP; a tie afterwards goes to req0
      set_req0(1, 16'd9, 16'd4, 4'b0001);
      cycle();
      set_req0(0, 0, 0, 0);
      reset = 1;
      cycle();
      reset = 0;
      set_req0(1, 16'd9, 16'd4, 4'b0001);
      set_req1(1, 16'd2, 16'd1, 4'b0010);
      rsp_ready = 0;
      cycle();
      set_req0(0, 0, 0, 0);
      set_req1(0, 0, 0, 0);
      cycle();
      cycle();
      reset = 1;
      cycle();
      reset = 0;
      set_req0(1, 16'd1, 16'd1, 4'b0001);
      set_req1(1, 16'd2, 16'd2, 4'b0001);
      rsp_ready = 1;
      cycle();
      set_req0(0, 0, 0, 0);
      set_req1(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle();

      // Random traffic, including rsp_ready outside RESP and rare resets
      for (int i = 0; i < 3000; i++) begin
         set_req0($urandom_range(0, 2) != 0, W'($urandom), W'($urandom), 4'($urandom));
         set_req1($urandom_range(0, 2) != 0, W'($urandom), W'($urandom), 4'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            req0_a = req0_b;
            req1_a = req1_b;
         end
         rsp_ready = $urandom_range(0, 3) != 0;
         reset = $urandom_range(0, 199) == 0;
         cycle();
      end
      idle_inputs();
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
